multicycle_ctrl: RTL and testbench

- Moore FSM that sequences the RV32I shared datapath: one ALU, one unified memory, instruction register.
- It is the multi-cycle counterpart of the main decoder and covers the same opcode set: lw, sw, R-type, I-type ALU, beq.
- It drives all datapath mux selects, write enables and the ALUOp hint consumed by the ALU decoder.
- Memory accesses use a req/ready handshake. A retired-instruction counter is maintained.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the shared-datapath RV32I core
// (lw, sw, R-type, I-type ALU, beq). Drives mux selects, write enables,
// the ALUOp hint and a retired-instruction counter.
// Optional feature macro: MC_JAL_EN adds the JAL state (Op=1101111).
module multicycle_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       Op,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ImmSrc,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instret
);

   localparam int unsigned OP_W  = 7;
   localparam int unsigned SEL_W = 2;

   localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9
`ifdef MC_JAL_EN
      ,JAL     = 4'd10
`endif
   } state_t;

   typedef struct packed {
      logic             memReq;
      logic             adrSrc;
      logic             regWrite;
      logic             memWrite;
      logic             branch;
      logic             jalUpdate;
      logic [SEL_W-1:0] resultSrc;
      logic [SEL_W-1:0] aluSrcA;
      logic [SEL_W-1:0] aluSrcB;
      logic [SEL_W-1:0] aluOp;
   } ctrl_t;

   state_t state;
   state_t nextState;
   ctrl_t  ctrl;

   // Sequencing rules: where each state goes given opcode and memory status.
   function automatic state_t nextStateOf(input state_t s, input logic [OP_W-1:0] op,
                                          input logic rdy);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:    n = rdy ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: n = MEMADR;
               OP_R:         n = EXECR;
               OP_I:         n = EXECI;
               OP_BEQ:       n = BEQ;
`ifdef MC_JAL_EN
               OP_JAL:       n = JAL;
`endif
               default:      n = FETCH;
            endcase
         end
         MEMADR:   n = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  n = rdy ? MEMWB : MEMREAD;
         MEMWB:    n = FETCH;
         MEMWRITE: n = rdy ? FETCH : MEMWRITE;
         EXECR:    n = ALUWB;
         EXECI:    n = ALUWB;
         ALUWB:    n = FETCH;
         BEQ:      n = FETCH;
`ifdef MC_JAL_EN
         JAL:      n = ALUWB;
`endif
         default:  n = FETCH;
      endcase
      return n;
   endfunction

   // Moore control word for a state; anything not set stays 0.
   function automatic ctrl_t ctrlOf(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.memReq    = 1'b1;
            c.aluSrcB   = 2'b10;
            c.resultSrc = 2'b10;
         end
         DECODE: begin
            c.aluSrcA = 2'b01;
            c.aluSrcB = 2'b01;
         end
         MEMADR: begin
            c.aluSrcA = 2'b10;
            c.aluSrcB = 2'b01;
         end
         MEMREAD: begin
            c.memReq = 1'b1;
            c.adrSrc = 1'b1;
         end
         MEMWB: begin
            c.resultSrc = 2'b01;
            c.regWrite  = 1'b1;
         end
         MEMWRITE: begin
            c.memReq   = 1'b1;
            c.adrSrc   = 1'b1;
            c.memWrite = 1'b1;
         end
         EXECR: begin
            c.aluSrcA = 2'b10;
            c.aluOp   = 2'b10;
         end
         EXECI: begin
            c.aluSrcA = 2'b10;
            c.aluSrcB = 2'b01;
            c.aluOp   = 2'b10;
         end
         ALUWB: c.regWrite = 1'b1;
         BEQ: begin
            c.aluSrcA = 2'b10;
            c.aluOp   = 2'b01;
            c.branch  = 1'b1;
         end
`ifdef MC_JAL_EN
         JAL: begin
            c.aluSrcA   = 2'b01;
            c.aluSrcB   = 2'b10;
            c.jalUpdate = 1'b1;
         end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

   assign nextState = nextStateOf(state, Op, mem_ready);

   // State, control word (decoded from the upcoming state) and retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         ctrl    <= ctrlOf(FETCH);
         instret <= '0;
      end else begin
         state <= nextState;
         ctrl  <= ctrlOf(nextState);
         if (instr_done) instret <= instret + CNT_W'(1);
      end
   end

   // Registered control word onto the ports.
   assign mem_req   = ctrl.memReq;
   assign AdrSrc    = ctrl.adrSrc;
   assign RegWrite  = ctrl.regWrite;
   assign MemWrite  = ctrl.memWrite;
   assign ResultSrc = ctrl.resultSrc;
   assign ALUSrcA   = ctrl.aluSrcA;
   assign ALUSrcB   = ctrl.aluSrcB;
   assign ALUOp     = ctrl.aluOp;

   // Handshake/flag-qualified strobes; mem_ready only matters in FETCH and MEMWRITE here.
   assign IRWrite    = (state == FETCH) && mem_ready;
   assign PCWrite    = IRWrite || ctrl.jalUpdate || (ctrl.branch && Zero);
   assign instr_done = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                       ((state == MEMWRITE) && mem_ready);
   assign illegal_op = (state == DECODE) && (nextState == FETCH);

   // Immediate format select straight from the opcode.
   always_comb begin
      ImmSrc = 2'b00;
      case (Op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases then random
// instruction streams with random memory wait states.
module tb_multicycle_ctrl;

   localparam int unsigned CNT_W = 32;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       Op;
   logic             Zero;
   logic             mem_ready;
   logic             mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
   logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic             instr_done, illegal_op;
   logic [CNT_W-1:0] instret;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
      .instr_done(instr_done), .illegal_op(illegal_op), .instret(instret)
   );

   always #5 clk = ~clk;

   // One cycle's worth of expected port values.
   typedef struct packed {
      logic       memReq, adrSrc, irWrite, pcWrite, regWrite, memWrite;
      logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
      logic       done, illegal;
   } exp_t;

   exp_t             expQ[$];
   logic             rdyQ[$];
   logic             zQ[$];
   int               checks = 0;
   int               fails = 0;
   logic [CNT_W-1:0] retired = '0;
   int               cycleNo = 0;

   function automatic exp_t mk(input logic mr, ad, ir, pc, rw, mw,
                               input logic [1:0] rs, sa, sb, ao,
                               input logic dn, il);
      exp_t e;
      e = '{mr, ad, ir, pc, rw, mw, rs, sa, sb, ao, dn, il};
      return e;
   endfunction

   function automatic exp_t fetchExp(input logic rdy);
      return mk(1, 0, rdy, rdy, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
   endfunction

   // Instruction class from the opcode: 0 lw,1 sw,2 R,3 I,4 beq,5 jal,6 illegal.
   function automatic int classify(input logic [6:0] op);
      case (op)
         OP_LW:  return 0;
         OP_SW:  return 1;
         OP_R:   return 2;
         OP_I:   return 3;
         OP_BEQ: return 4;
`ifdef MC_JAL_EN
         OP_JAL: return 5;
`endif
         default: return 6;
      endcase
   endfunction

   function automatic logic [1:0] immOf(input logic [6:0] op);
      if (op == OP_SW)  return 2'b01;
      if (op == OP_BEQ) return 2'b10;
      if (op == OP_JAL) return 2'b11;
      return 2'b00;
   endfunction

   task automatic push(input exp_t e, input logic rdy, input logic z);
      expQ.push_back(e);
      rdyQ.push_back(rdy);
      zQ.push_back(z);
   endtask

   // Expected cycle-by-cycle behaviour of one instruction.
   // fw: FETCH wait cycles, mw: MEMREAD/MEMWRITE wait cycles, z: Zero in BEQ.
   task automatic plan(input logic [6:0] op, input logic z, input int fw, input int mw);
      int cls;
      expQ.delete(); rdyQ.delete(); zQ.delete();
      cls = classify(op);
      for (int i = 0; i < fw; i++) push(fetchExp(0), 0, 1'($urandom));
      push(fetchExp(1), 1, 1'($urandom));
      push(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, cls == 6),
           1'($urandom), 1'($urandom));
      case (cls)
         0: begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0), 1'($urandom), 1'($urandom));
            for (int i = 0; i < mw; i++)
               push(mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0), 0, 1'($urandom));
            push(mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0), 1, 1'($urandom));
            push(mk(0,0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,1,0), 1'($urandom), 1'($urandom));
         end
         1: begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0), 1'($urandom), 1'($urandom));
            for (int i = 0; i < mw; i++)
               push(mk(1,1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0), 0, 1'($urandom));
            push(mk(1,1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0), 1, 1'($urandom));
         end
         2, 3: begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,(cls == 3) ? 2'b01 : 2'b00,2'b10,0,0),
                 1'($urandom), 1'($urandom));
            push(mk(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,1,0), 1'($urandom), 1'($urandom));
         end
         4: push(mk(0,0,0,z,0,0,2'b00,2'b10,2'b00,2'b01,1,0), 1'($urandom), z);
         5: begin
            push(mk(0,0,0,1,0,0,2'b00,2'b01,2'b10,2'b00,0,0), 1'($urandom), 1'($urandom));
            push(mk(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,1,0), 1'($urandom), 1'($urandom));
         end
         default: ;
      endcase
   endtask

   // Play the planned cycles; optionally assert rst during cycle abortAt and stop there.
   task automatic runSeq(input int abortAt);
      exp_t obs;
      for (int i = 0; i < expQ.size(); i++) begin
         mem_ready = rdyQ[i];
         Zero      = zQ[i];
         rst       = (i == abortAt);
         #1;
         obs = '{mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op};
         checks++;
         assert (obs === expQ[i]) else begin
            fails++;
            $error("FAIL ctrl cycle %0d step %0d op=%b observed=%h expected=%h",
                   cycleNo, i, Op, obs, expQ[i]);
         end
         cycleNo++;
         @(negedge clk);
         if (i == abortAt) begin
            rst = 1'b0;
            retired = '0;
            return;
         end
      end
   endtask

   task automatic checkCounters(input string tag);
      checks++;
      assert (instret === retired) else begin
         fails++;
         $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, retired);
      end
      checks++;
      assert (ImmSrc === immOf(Op)) else begin
         fails++;
         $error("FAIL %s ImmSrc op=%b observed=%b expected=%b", tag, Op, ImmSrc, immOf(Op));
      end
   endtask

   task automatic doInstr(input logic [6:0] op, input logic z, input int fw, input int mw,
                          input string tag);
      Op = op;
      plan(op, z, fw, mw);
      runSeq(-1);
      if (classify(op) != 6) retired = retired + CNT_W'(1);
      checkCounters(tag);
   endtask

   initial begin
      logic [6:0] ops[8];
      logic [6:0] op;
      ops[0] = OP_LW;  ops[1] = OP_SW;  ops[2] = OP_R;   ops[3] = OP_I;
      ops[4] = OP_BEQ; ops[5] = OP_JAL; ops[6] = 7'h7F;  ops[7] = 7'h00;

      // Reset for two edges with memory idle.
      rst = 1'b1; mem_ready = 1'b0; Zero = 1'b0; Op = OP_LW;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      assert (instret === '0) else begin
         fails++; $error("FAIL reset instret observed=%0d expected=0", instret);
      end
      checks++;
      assert ({mem_req, IRWrite, PCWrite} === 3'b100) else begin
         fails++; $error("FAIL reset handshake observed=%b expected=100", {mem_req, IRWrite, PCWrite});
      end
      @(negedge clk);

      // Directed: lw after held FETCH, lw zero-wait, sw with 3 waits, beq taken/not, illegal, jal.
      doInstr(OP_LW, 1'b0, 3, 0, "lw_fetchwait");
      doInstr(OP_LW, 1'b0, 0, 0, "lw");
      doInstr(OP_SW, 1'b0, 0, 3, "sw_wait3");
      doInstr(OP_BEQ, 1'b1, 0, 0, "beq_taken");
      doInstr(OP_BEQ, 1'b0, 0, 0, "beq_not_taken");
      doInstr(OP_R, 1'b0, 0, 0, "rtype");
      doInstr(OP_I, 1'b0, 1, 0, "itype");
      doInstr(7'h7F, 1'b0, 0, 0, "illegal");
      doInstr(OP_JAL, 1'b0, 0, 0, "jal");

      // Reset asserted during the first MEMREAD cycle of a waiting lw.
      Op = OP_LW;
      plan(OP_LW, 1'b0, 0, 2);
      runSeq(3);
      mem_ready = 1'b0;
      #1;
      checks++;
      assert ({mem_req, AdrSrc, RegWrite, ALUSrcB, ResultSrc, instret} ===
              {1'b1, 1'b0, 1'b0, 2'b10, 2'b10, CNT_W'(0)}) else begin
         fails++;
         $error("FAIL rst_memread observed=%b%b%b %b %b cnt=%0d expected=100 10 10 cnt=0",
                mem_req, AdrSrc, RegWrite, ALUSrcB, ResultSrc, instret);
      end
      @(negedge clk);

      // Random instruction stream with random waits.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 8))
            8:       op = 7'($urandom);
            default: op = ops[$urandom_range(0, 7)];
         endcase
         doInstr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
